tt_um_hoene_shift_out_with_parity: RTL and testbench

Serial transmitter for the 32-bit LED chain frame: 30 data bits, 1 use flag, 1 parity bit.
- Accepts a 30-bit payload plus use flag over a valid/ready handshake.
- Computes the parity bit.
- Serialises the frame on a data/strobe pair that the chain's shift-in receiver samples on the strobe's rising edge.
- Sits at the downstream output of each LED cell (and in the test driver) to forward frames to the next cell.

---
 rtl/tt_um_hoene_shift_out_with_parity.sv | 169 ++++++++++++++++
 tb/tb_tt_um_hoene_shift_out_with_parity.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_hoene_shift_out_with_parity.sv
// rtl/tt_um_hoene_shift_out_with_parity.sv - serial frame transmitter with parity for the LED chain
//
// Sends one 32-bit frame {parity, tx_use, tx_data[29:0]} LSB first on an
// out_data/out_clock pair. The receiver samples out_data on the rising edge
// of out_clock.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   tx_data[29:0]       payload (frame bits 29:0)
//   tx_use              use flag (frame bit 30)
//   tx_valid/tx_ready   accept handshake, taken only in IDLE
//   out_data, out_clock serial data and strobe
//   busy                high while not IDLE
//   done                one-cycle pulse on the first IDLE cycle after a frame
//
// Parameters: CLK_DIV (strobe half-period, 1..255), GAP_CYCLES (idle gap after a frame).
// Build option: define SHIFT_OUT_ODD_PARITY_EN for odd parity (default even).

module tt_um_hoene_shift_out_with_parity #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [29:0] tx_data,
  input  logic        tx_use,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        out_data,
  output logic        out_clock,
  output logic        busy,
  output logic        done
);

  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_GAP} state_t;

  state_t        state, state_n;
  logic [7:0]    div_cnt, div_cnt_n;
  logic [4:0]    bit_idx, bit_idx_n;
  logic [GW-1:0] gap_cnt, gap_cnt_n;
  logic [31:0]   shift_reg, shift_reg_n;
  logic          tx_ready_n, out_data_n, out_clock_n, busy_n, done_n;

  logic          parity;
  logic [31:0]   frame;

`ifdef SHIFT_OUT_ODD_PARITY_EN
  assign parity = ~(^{tx_use, tx_data});
`else
  assign parity = ^{tx_use, tx_data};
`endif
  assign frame = {parity, tx_use, tx_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      bit_idx   <= '0;
      gap_cnt   <= '0;
      shift_reg <= '0;
      tx_ready  <= 1'b1;
      out_data  <= 1'b0;
      out_clock <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      div_cnt   <= div_cnt_n;
      bit_idx   <= bit_idx_n;
      gap_cnt   <= gap_cnt_n;
      shift_reg <= shift_reg_n;
      tx_ready  <= tx_ready_n;
      out_data  <= out_data_n;
      out_clock <= out_clock_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  // Outputs are computed here as next-cycle values and registered above,
  // so every output pin comes straight from a flop.
  always_comb begin
    state_n     = state;
    div_cnt_n   = div_cnt;
    bit_idx_n   = bit_idx;
    gap_cnt_n   = gap_cnt;
    shift_reg_n = shift_reg;
    tx_ready_n  = tx_ready;
    out_data_n  = out_data;
    out_clock_n = out_clock;
    busy_n      = busy;
    done_n      = 1'b0;

    case (state)
      S_IDLE: begin
        if (tx_valid) begin
          state_n     = S_LOW;
          shift_reg_n = frame;
          out_data_n  = frame[0];
          out_clock_n = 1'b0;
          div_cnt_n   = '0;
          bit_idx_n   = '0;
          tx_ready_n  = 1'b0;
          busy_n      = 1'b1;
        end
      end

      S_LOW: begin
        if (div_cnt == DIV_LAST) begin
          state_n     = S_HIGH;
          div_cnt_n   = '0;
          out_clock_n = 1'b1;
        end else begin
          div_cnt_n = div_cnt + 8'd1;
        end
      end

      S_HIGH: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_n   = '0;
          out_clock_n = 1'b0;
          if (bit_idx != 5'd31) begin
            // Next bit appears together with the strobe's falling edge.
            state_n     = S_LOW;
            bit_idx_n   = bit_idx + 5'd1;
            shift_reg_n = {1'b0, shift_reg[31:1]};
            out_data_n  = shift_reg[1];
          end else begin
            shift_reg_n = '0;
            out_data_n  = 1'b0;
            bit_idx_n   = '0;
            if (GAP_CYCLES == 0) begin
              state_n    = S_IDLE;
              tx_ready_n = 1'b1;
              busy_n     = 1'b0;
              done_n     = 1'b1;
            end else begin
              state_n   = S_GAP;
              gap_cnt_n = '0;
            end
          end
        end else begin
          div_cnt_n = div_cnt + 8'd1;
        end
      end

      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_n    = S_IDLE;
          gap_cnt_n  = '0;
          tx_ready_n = 1'b1;
          busy_n     = 1'b0;
          done_n     = 1'b1;
        end else begin
          gap_cnt_n = gap_cnt + GW'(1);
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_tt_um_hoene_shift_out_with_parity.sv
// tb/tb_tt_um_hoene_shift_out_with_parity.sv - self-checking bench for the serial frame transmitter

module tb_tt_um_hoene_shift_out_with_parity;

  localparam int CLK_DIV  = 2;
  localparam int GAP      = 4;
  localparam int BUSY_LEN = 64 * CLK_DIV + GAP;

`ifdef SHIFT_OUT_ODD_PARITY_EN
  localparam logic [31:0] PFLIP = 32'h8000_0000;
`else
  localparam logic [31:0] PFLIP = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [29:0] tx_data = '0;
  logic        tx_use = 1'b0;
  logic        tx_valid = 1'b0;
  logic        tx_ready, out_data, out_clock, busy, done;

  tt_um_hoene_shift_out_with_parity #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_use(tx_use), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .out_data(out_data), .out_clock(out_clock), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [31:0] exp_q[$];
  int rx_bits = 0;
  int rx_frames = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  int idle_run = 0;
  int last_idle_run = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Receiver model and protocol monitor, sampled on the falling clk edge.
  initial begin
    logic        prev_clk, prev_data, prev_busy, prev_done;
    logic [31:0] rx_sh;
    int          cyc, last_rise;
    prev_clk = 0; prev_data = 0; prev_busy = 0; prev_done = 0;
    rx_sh = '0; cyc = 0; last_rise = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        rx_bits  = 0;
        busy_cnt = 0;
      end else begin
        if (out_clock && prev_clk)
          check("data_stable_high", 32'(out_data), 32'(prev_data));
        if (out_clock && !prev_clk) begin
          if (rx_bits > 0)
            check("strobe_period", 32'(cyc - last_rise), 32'(2 * CLK_DIV));
          last_rise = cyc;
          rx_sh[rx_bits] = out_data;
          rx_bits++;
          if (rx_bits == 32) begin
            rx_bits = 0;
            rx_frames++;
            if (exp_q.size() == 0) begin
              total++; bad++;
              $display("FAIL frame_unexpected: got %h expected none", rx_sh);
            end else begin
              check("frame", rx_sh, exp_q.pop_front());
            end
          end
        end
        if (busy) busy_cnt++;
        if (busy && !prev_busy) begin
          last_idle_run = idle_run;
          idle_run = 0;
        end
        if (!busy) idle_run++;
        if (done) begin
          done_cnt++;
          check("busy_len", 32'(busy_cnt), 32'(BUSY_LEN));
          check("done_ready", 32'(tx_ready), 32'd1);
          check("done_clock_low", 32'(out_clock), 32'd0);
          busy_cnt = 0;
          if (prev_done) check("done_single", 32'(prev_done), 32'd0);
        end
      end
      prev_clk = out_clock; prev_data = out_data; prev_busy = busy; prev_done = done;
    end
  end

  task automatic send(input logic [29:0] d, input logic u, input logic [31:0] e, input bit hold);
    int n;
    n = 0;
    @(negedge clk);
    while (!tx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) begin
      check("send_timeout_ready", 32'(tx_ready), 32'd1);
      return;
    end
    tx_data  = d;
    tx_use   = u;
    tx_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(e);
    @(negedge clk);
    tx_data = ~d;
    tx_use  = ~u;
    if (!hold) tx_valid = 1'b0;
    check("accept_ready_low", 32'(tx_ready), 32'd0);
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_bit0", 32'(out_data), 32'(e[0]));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !tx_ready) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [29:0] d;
    logic        u;
    logic [31:0] e;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n;
    vecs[0] = '{30'h0000_0001, 1'b0, 32'h8000_0001 ^ PFLIP};
    vecs[1] = '{30'h3FFF_FFFF, 1'b1, 32'hFFFF_FFFF ^ PFLIP};
    vecs[2] = '{30'h0000_0000, 1'b0, 32'h0000_0000 ^ PFLIP};
    vecs[3] = '{30'h0000_0000, 1'b1, 32'hC000_0000 ^ PFLIP};
    vecs[4] = '{30'h2AAA_AAAA, 1'b0, 32'hAAAA_AAAA ^ PFLIP};
    vecs[5] = '{30'h1555_5555, 1'b1, 32'h5555_5555 ^ PFLIP};

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_clock", 32'(out_clock), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      send(vecs[i].d, vecs[i].u, vecs[i].e, 1'b0);
      drain();
    end

    // Back-to-back with tx_valid held; payload is scrambled after each accept.
    send(30'h155, 1'b1, 32'h4000_0155 ^ PFLIP, 1'b1);
    send(30'h2AA, 1'b1, 32'h4000_02AA ^ PFLIP, 1'b0);
    drain();
    check("b2b_idle_cycles", 32'(last_idle_run), 32'd1);

    // Reset in the middle of a frame.
    send(30'h1, 1'b0, 32'h8000_0001 ^ PFLIP, 1'b0);
    n = 0;
    while (rx_bits < 10 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("mid_reset_reach", 32'(rx_bits), 32'd10);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_clock", 32'(out_clock), 32'd0);
    check("async_rst_data", 32'(out_data), 32'd0);
    check("async_rst_ready", 32'(tx_ready), 32'd1);
    check("async_rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send(30'h1, 1'b0, 32'h8000_0001 ^ PFLIP, 1'b0);
    drain();

    check("done_count", 32'(done_cnt), 32'(rx_frames));
    check("frames_received", 32'(rx_frames), 32'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
